rhd_spi_slave: RTL and testbench

RHD_SPI_SLAVE -- requirements
Module: rhd_spi_slave

---
 rtl/rhd_spi_slave_pkg.sv | 47 ++++
 rtl/rhd_spi_slave_if.sv | 10 +
 rtl/rhd_spi_slave_sync_edge.sv | 34 +++
 rtl/rhd_spi_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_rhd_spi_slave.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rhd_spi_slave_pkg.sv
// rhd_pkg: command opcodes, fixed command words, read-only register map and
// the "INTAN" identification bytes shared by the SPI slave and master side.
package rhd_pkg;

   typedef enum logic [1:0] {
      OP_CONVERT = 2'b00,
      OP_MISC    = 2'b01,
      OP_WRITE   = 2'b10,
      OP_READ    = 2'b11
   } rhd_op_e;

   localparam int unsigned FRAME_BITS    = 16;
   localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
   localparam logic [15:0] CMD_CLEAR     = 16'h6A00;
   localparam logic [15:0] RESULT_ACK    = 16'h0080;
   localparam logic [7:0]  WRITE_ECHO_HI = 8'hFF;
   localparam logic [7:0]  READ_HI       = 8'h00;

   localparam logic [5:0]  RO_INTAN_FIRST = 6'd40;
   localparam logic [5:0]  RO_INTAN_LAST  = 6'd44;
   localparam logic [5:0]  RO_CHIP_ID     = 6'd63;
   localparam logic [39:0] INTAN_STR      = "INTAN";

   // CONVERT is 00cccccc_0000000x; any other low byte is not a conversion
   function automatic logic is_convert(input logic [15:0] w);
      return (w[15:14] == OP_CONVERT) && (w[7:1] == 7'd0);
   endfunction

   function automatic logic is_read_only(input logic [5:0] addr);
      return ((addr >= RO_INTAN_FIRST) && (addr <= RO_INTAN_LAST)) ||
             (addr == RO_CHIP_ID);
   endfunction

   function automatic logic [7:0] intan_char(input logic [5:0] addr);
      logic [7:0] c;
      case (addr)
         6'd40:   c = INTAN_STR[39:32];
         6'd41:   c = INTAN_STR[31:24];
         6'd42:   c = INTAN_STR[23:16];
         6'd43:   c = INTAN_STR[15:8];
         6'd44:   c = INTAN_STR[7:0];
         default: c = 8'h00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rhd_spi_slave_if.sv
// SPI bus between the acquisition master and the rhd_spi_slave.
interface rhd_spi_slave_if;
   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;

   modport master (output sclk, output cs_n, output mosi, input miso);
   modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/rhd_spi_slave_sync_edge.sv
// rhd_sync_edge: multi-flop synchronizer with rising/falling edge detect on
// the synchronized level.
module rhd_sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;
   logic              level;

   assign level = chain[STAGES-1];

   // synchronizer chain plus one history flop for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{RESET_VAL}};
         prev  <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= level;
      end
   end

   assign rise = level & ~prev;
   assign fall = ~level & prev;

endmodule

// File: rtl/rhd_spi_slave.sv
// rhd_spi_slave: 16-bit command SPI slave for an RHD-style amplifier.
// Decodes CONVERT/WRITE/READ/CALIBRATE/CLEAR, returns each result two valid
// frames later on miso. Define RHD_SPI_SLAVE_DDR_EN for 32-bit results with
// a second word (channel B) interleaved on sclk rising edges.
module rhd_spi_slave
   import rhd_pkg::*;
#(
   parameter logic [7:0]  CHIP_ID     = 8'd1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   rhd_spi_slave_if.slave   spi,
   output logic             sample_strobe,
   output logic [5:0]       sample_channel,
   input  logic [15:0]      sample_data,
   output logic             frame_done,
   output logic [15:0]      cmd_out,
   output logic             frame_err
);

   localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef RHD_SPI_SLAVE_DDR_EN
   localparam int unsigned RW = 32;
`else
   localparam int unsigned RW = 16;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_END} state_e;

   state_e            state_q, state_d;
   logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [SYNC_N-1:0] mosi_sync;
   logic              mosi_s;
   logic              frame_start, take_bit, frame_ok, frame_bad, do_decode;
   logic [4:0]        cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       word_q, word_d;
   logic [7:0]        regs [64];
   logic [RW-1:0]     pipe_new, pipe_old, result;
   rhd_op_e           op;
   logic [5:0]        addr;
   logic [7:0]        data, reg_rd;
   logic              wr_en;
   logic [15:0]       res_a;
   logic [15:0]       a_sr;
   logic              miso_q;
`ifdef RHD_SPI_SLAVE_DDR_EN
   logic [15:0]       res_b;
   logic [15:0]       b_sr;
`endif

   // Both chains reset low: a cs_n falling edge is only seen after cs_n has
   // been observed high, so a frame in flight at reset release is skipped.
   rhd_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(spi.sclk), .rise(sclk_rise), .fall(sclk_fall)
   );

   rhd_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_cs (
      .clk(clk), .rst(rst), .din(spi.cs_n), .rise(cs_rise), .fall(cs_fall)
   );

   // mosi delayed by the same depth so it lines up with synchronized sclk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mosi_sync <= '0;
      else     mosi_sync <= {mosi_sync[SYNC_N-2:0], spi.mosi};
   end
   assign mosi_s = mosi_sync[SYNC_N-1];

   assign frame_start = (state_q == ST_IDLE) && cs_fall;
   assign take_bit    = (state_q == ST_SHIFT) && sclk_rise;

   // bit counter (saturating at 16, overflow remembered) and shift register;
   // an sclk edge coincident with cs_n rising is folded in before the end check
   always_comb begin
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      word_d = word_q;
      if (frame_start) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (take_bit) begin
         if (cnt_q == 5'd16) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + 5'd1;
            word_d = {word_q[14:0], mosi_s};
         end
      end
   end

   // frame state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // frame sequencing: IDLE -> SHIFT -> END (valid) or IDLE (bad count)
   always_comb begin
      state_d   = state_q;
      frame_ok  = 1'b0;
      frame_bad = 1'b0;
      do_decode = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_start) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               if ((cnt_d == 5'd16) && !ovf_d) begin
                  frame_ok = 1'b1;
                  state_d  = ST_END;
               end else begin
                  frame_bad = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_END: begin
            do_decode = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // counter and command shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         word_q <= word_d;
      end
   end

   // command decode and result formation for the word held during END
   always_comb begin
      op     = rhd_op_e'(word_q[15:14]);
      addr   = word_q[13:8];
      data   = word_q[7:0];
      wr_en  = 1'b0;
      res_a  = '0;
`ifdef RHD_SPI_SLAVE_DDR_EN
      res_b  = '0;
`endif
      if (addr == RO_CHIP_ID)        reg_rd = CHIP_ID;
      else if (is_read_only(addr))   reg_rd = intan_char(addr);
      else                           reg_rd = regs[addr];
      if (is_convert(word_q)) begin
         res_a = sample_data;
`ifdef RHD_SPI_SLAVE_DDR_EN
         res_b = ~sample_data;
`endif
      end else if (op == OP_WRITE) begin
         res_a = {WRITE_ECHO_HI, data};
         wr_en = !is_read_only(addr);
      end else if (op == OP_READ) begin
         res_a = {READ_HI, reg_rd};
      end else if ((word_q == CMD_CALIBRATE) || (word_q == CMD_CLEAR)) begin
         res_a = RESULT_ACK;
      end
   end

`ifdef RHD_SPI_SLAVE_DDR_EN
   assign result = {res_a, res_b};
`else
   assign result = res_a;
`endif

   // strobe is raised entering END so sample_data is taken in that same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_strobe  <= 1'b0;
         sample_channel <= '0;
         frame_done     <= 1'b0;
         frame_err      <= 1'b0;
         cmd_out        <= '0;
      end else begin
         sample_strobe <= frame_ok && is_convert(word_d);
         if (frame_ok && is_convert(word_d)) sample_channel <= word_d[13:8];
         frame_done <= do_decode;
         frame_err  <= frame_bad;
         if (do_decode) cmd_out <= word_q;
      end
   end

   // writable register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      regs <= '{default: '0};
      else if (do_decode && wr_en)  regs[addr] <= data;
   end

   // two-deep result pipeline, advanced only by valid frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_new <= '0;
         pipe_old <= '0;
      end else if (do_decode) begin
         pipe_old <= pipe_new;
         pipe_new <= result;
      end
   end

   // miso shifter: A bits advance on sclk falls; in DDR builds the B bit of
   // the same position is shown after each sclk rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         miso_q <= 1'b0;
`ifdef RHD_SPI_SLAVE_DDR_EN
         b_sr   <= '0;
`endif
      end else if (frame_start) begin
         a_sr   <= pipe_old[RW-1 -: 16];
         miso_q <= pipe_old[RW-1];
`ifdef RHD_SPI_SLAVE_DDR_EN
         b_sr   <= pipe_old[15:0];
`endif
      end else if (state_q == ST_SHIFT) begin
         if (sclk_fall) begin
            a_sr   <= {a_sr[14:0], 1'b0};
            miso_q <= a_sr[14];
`ifdef RHD_SPI_SLAVE_DDR_EN
            b_sr   <= {b_sr[14:0], 1'b0};
`endif
         end
`ifdef RHD_SPI_SLAVE_DDR_EN
         else if (sclk_rise) begin
            miso_q <= b_sr[15];
         end
`endif
      end
   end

   assign spi.miso = miso_q;

endmodule

// File: tb/tb_rhd_spi_slave.sv
// Self-checking bench for rhd_spi_slave: directed frames followed by random
// frames, checked against a rule-level model of registers and result delay.
module tb_rhd_spi_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_strobe;
   logic [5:0]  sample_channel;
   logic [15:0] sample_data;
   logic        frame_done;
   logic [15:0] cmd_out;
   logic        frame_err;

   rhd_spi_slave_if spi ();

   rhd_spi_slave #(.CHIP_ID(8'd1), .SYNC_STAGES(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .spi            (spi),
      .sample_strobe  (sample_strobe),
      .sample_channel (sample_channel),
      .sample_data    (sample_data),
      .frame_done     (frame_done),
      .cmd_out        (cmd_out),
      .frame_err      (frame_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // pulse counters sampled on the falling clock edge
   int         n_done = 0;
   int         n_ferr = 0;
   int         n_strobe = 0;
   logic [5:0] last_ch = '0;

   always @(negedge clk) begin
      if (frame_done)    n_done++;
      if (frame_err)     n_ferr++;
      if (sample_strobe) begin
         n_strobe++;
         last_ch = sample_channel;
      end
   end

   // reference model
   logic [7:0]  m_regs [64];
   logic [31:0] m_pipe [2];     // [0] is returned in the next frame
   logic [15:0] m_cmd;
   logic [39:0] id_str = "INTAN";
   logic [7:0]  tb_chip = 8'd1;

   function automatic logic [7:0] m_read(input logic [5:0] a);
      case (a)
         6'd40:   return id_str[39:32];
         6'd41:   return id_str[31:24];
         6'd42:   return id_str[23:16];
         6'd43:   return id_str[15:8];
         6'd44:   return id_str[7:0];
         6'd63:   return tb_chip;
         default: return m_regs[a];
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
      m_pipe[0] = '0;
      m_pipe[1] = '0;
      m_cmd     = '0;
   endtask

   task automatic model_frame(input logic [15:0] c, input logic [15:0] sd);
      logic [31:0] res;
      int          a;
      a = int'(c[13:8]);
      if (c[15:14] == 2'b00 && c[7:1] == 7'd0) begin
         res = {sd, ~sd};
      end else if (c[15:14] == 2'b10) begin
         res = {8'hFF, c[7:0], 16'h0000};
         if (!((a >= 40 && a <= 44) || a == 63)) m_regs[a] = c[7:0];
      end else if (c[15:14] == 2'b11) begin
         res = {8'h00, m_read(c[13:8]), 16'h0000};
      end else if (c == 16'h5500 || c == 16'h6A00) begin
         res = {16'h0080, 16'h0000};
      end else begin
         res = '0;
      end
      m_pipe[0] = m_pipe[1];
      m_pipe[1] = res;
      m_cmd     = c;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // clocks out n bits of c MSB first; ra sampled before each rise, rb before each fall
   task automatic shift_bits(input logic [15:0] c, input int n,
                             output logic [15:0] ra, output logic [15:0] rb);
      ra = '0;
      rb = '0;
      for (int i = 0; i < n; i++) begin
         spi.mosi = c[15-i];
         #50;
         ra = {ra[14:0], spi.miso};
         spi.sclk = 1'b1;
         #45;
         rb = {rb[14:0], spi.miso};
         #5;
         spi.sclk = 1'b0;
      end
   endtask

   task automatic full_frame(input logic [15:0] c, input logic [15:0] sd,
                             output logic [15:0] ra, output logic [15:0] rb);
      int          d0, e0, s0;
      logic [31:0] exp_rx;
      logic        conv;
      sample_data = sd;
      d0 = n_done; e0 = n_ferr; s0 = n_strobe;
      exp_rx = m_pipe[0];
      conv = (c[15:14] == 2'b00) && (c[7:1] == 7'd0);
      spi.cs_n = 1'b0;
      #100;
      shift_bits(c, 16, ra, rb);
      #40;
      chk("miso_zero_after_16", 32'(spi.miso), 32'd0);
      spi.cs_n = 1'b1;
      #200;
      model_frame(c, sd);
      chk($sformatf("rx_a cmd=%h", c), 32'(ra), 32'(exp_rx[31:16]));
`ifdef RHD_SPI_SLAVE_DDR_EN
      chk($sformatf("rx_b cmd=%h", c), 32'(rb), 32'(exp_rx[15:0]));
`endif
      chk("frame_done_count", 32'(n_done - d0), 32'd1);
      chk("frame_err_none", 32'(n_ferr - e0), 32'd0);
      chk("cmd_out", 32'(cmd_out), 32'(c));
      chk("strobe_count", 32'(n_strobe - s0), conv ? 32'd1 : 32'd0);
      if (conv) chk("sample_channel", 32'(last_ch), 32'(c[13:8]));
   endtask

   task automatic short_frame(input logic [15:0] c, input int n);
      int          d0, e0, s0;
      logic [15:0] ra, rb;
      d0 = n_done; e0 = n_ferr; s0 = n_strobe;
      spi.cs_n = 1'b0;
      #100;
      shift_bits(c, n, ra, rb);
      #50;
      spi.cs_n = 1'b1;
      #200;
      chk($sformatf("short_err n=%0d", n), 32'(n_ferr - e0), 32'd1);
      chk("short_no_done", 32'(n_done - d0), 32'd0);
      chk("short_no_strobe", 32'(n_strobe - s0), 32'd0);
      chk("short_cmd_out_kept", 32'(cmd_out), 32'(m_cmd));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_miso", 32'(spi.miso), 32'd0);
      chk("rst_sample_strobe", 32'(sample_strobe), 32'd0);
      chk("rst_sample_channel", 32'(sample_channel), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_cmd_out", 32'(cmd_out), 32'd0);
   endtask

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [15:0]  ra, rb, c;
      int unsigned  kind;
      int           e0;

      rst = 1'b1;
      spi.cs_n = 1'b1;
      spi.sclk = 1'b0;
      spi.mosi = 1'b0;
      sample_data = '0;
      model_reset();
      repeat (5) @(negedge clk);
      chk_reset_outputs();
      rst = 1'b0;
      #100;

      // write reg 5, then two conversions; third frame returns the echo
      full_frame(16'h8542, 16'h0000, ra, rb);
      full_frame(16'h0300, 16'hBEEF, ra, rb);
      full_frame(16'h0C00, 16'h1234, ra, rb);
      chk("write_echo_FF42", 32'(ra), 32'h0000FF42);
      full_frame(16'hE800, 16'h0000, ra, rb);
      chk("convert_ch3_result", 32'(ra), 32'h0000BEEF);
      full_frame(16'hFF00, 16'h0000, ra, rb);
      chk("convert_ch12_result", 32'(ra), 32'h00001234);
      full_frame(16'hC500, 16'h0000, ra, rb);
      chk("read_reg40_I", 32'(ra), 32'h00000049);
      short_frame(16'h8577, 12);
      full_frame(16'h5500, 16'h0000, ra, rb);
      chk("read_chip_id", 32'(ra), 32'h00000001);
      full_frame(16'h6A00, 16'h0000, ra, rb);
      chk("read_reg5_42", 32'(ra), 32'h00000042);
      full_frame(16'h1234, 16'h0000, ra, rb);
      chk("calibrate_ack", 32'(ra), 32'h00000080);
      full_frame(16'h8B11, 16'h0000, ra, rb);
      chk("clear_ack", 32'(ra), 32'h00000080);
      full_frame(16'hA8AA, 16'h0000, ra, rb);
      chk("other_zero", 32'(ra), 32'h00000000);
      full_frame(16'hE800, 16'h0000, ra, rb);
      full_frame(16'hCB00, 16'h0000, ra, rb);
      chk("ro_write_echo", 32'(ra), 32'h0000FFAA);
      full_frame(16'h0000, 16'h0000, ra, rb);
      chk("ro_reg40_unchanged", 32'(ra), 32'h00000049);
      full_frame(16'h0000, 16'h0000, ra, rb);
      chk("reg11_written", 32'(ra), 32'h00000011);

`ifdef RHD_SPI_SLAVE_DDR_EN
      full_frame(16'h0000, 16'h00FF, ra, rb);
      full_frame(16'h1234, 16'h0000, ra, rb);
      full_frame(16'h1234, 16'h0000, ra, rb);
      chk("ddr_a_00FF", 32'(ra), 32'h000000FF);
      chk("ddr_b_FF00", 32'(rb), 32'h0000FF00);
`endif

      // random traffic against the model
      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 5);
         case (kind)
            0: c = {2'b10, 6'($urandom_range(0, 63)), 8'($urandom)};
            1: c = {2'b11, 6'($urandom_range(0, 63)), 8'($urandom)};
            2: c = {2'b00, 6'($urandom_range(0, 63)), 7'd0, 1'($urandom)};
            3: c = ($urandom_range(0, 1) == 0) ? 16'h5500 : 16'h6A00;
            default: c = 16'($urandom);
         endcase
         if (kind == 5) short_frame(c, int'($urandom_range(0, 15)));
         else           full_frame(c, 16'($urandom), ra, rb);
      end

      // reset in the middle of a frame
      spi.cs_n = 1'b0;
      #100;
      shift_bits(16'hC500, 8, ra, rb);
      #20;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst = 1'b0;
      e0 = n_ferr;
      #100;
      spi.cs_n = 1'b1;
      #200;
      chk("abandoned_no_err", 32'(n_ferr - e0), 32'd0);
      model_reset();
      full_frame(16'h8A5A, 16'h0000, ra, rb);
      chk("post_rst_pipe_zero", 32'(ra), 32'h00000000);
      full_frame(16'hC500, 16'h0000, ra, rb);
      full_frame(16'hCA00, 16'h0000, ra, rb);
      chk("post_rst_write_echo", 32'(ra), 32'h0000FF5A);
      full_frame(16'h0000, 16'h0000, ra, rb);
      chk("post_rst_reg5_cleared", 32'(ra), 32'h00000000);
      full_frame(16'h0000, 16'h0000, ra, rb);
      chk("post_rst_reg10", 32'(ra), 32'h0000005A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
